spi_reg_controller: RTL and testbench

//  Frame-level controller above spi_secondary: decodes received words into register accesses and

---
 rtl/spi_reg_pkg.sv | 16 +
 rtl/cs_synchronizer.sv | 23 ++
 rtl/spi_reg_controller.sv | 119 +++++++++++
 tb/tb_spi_reg_controller.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register-access controller.
package spi_reg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WR_DATA,
    RD_FETCH,
    RD_STREAM
  } state_t;

  localparam int DefaultWordBits = 8;
  localparam int CmdReadBit = DefaultWordBits - 1;
  localparam logic [7:0] DefaultTurnaround = 8'hA5;

endpackage

// File: rtl/cs_synchronizer.sv
// Two-flop synchronizer for slow asynchronous SPI inputs; resets to the idle level.
module cs_synchronizer #(
  parameter logic ResetVal = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= ResetVal;
      q    <= ResetVal;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_reg_controller.sv
// Frame-level controller: turns received SPI words into register accesses and
// sequences the next word to shift out (status, turnaround, read data).
module spi_reg_controller
  import spi_reg_pkg::*;
#(
  parameter int WordBits = DefaultWordBits,
  parameter int AddrBits = 7,
  parameter logic [WordBits-1:0] Turnaround = WordBits'(DefaultTurnaround)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cs,
  input  logic                word_ready,
  input  logic [WordBits-1:0] data_word_received,
  output logic [WordBits-1:0] data_word_to_send,
  output logic [AddrBits-1:0] reg_addr,
  output logic [WordBits-1:0] reg_wdata,
  output logic                reg_we,
  output logic                reg_re,
  input  logic [WordBits-1:0] reg_rdata,
  input  logic [WordBits-1:0] status_word,
  output logic                frame_active
);

  localparam int ReadBit = WordBits - 1;

  state_t              state;
  state_t              next_state;
  logic                cs_s;
  logic                fetch_due;
  logic [WordBits-1:0] tx_q;

  cs_synchronizer #(.ResetVal(1'b1)) u_cs_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (cs),
    .q    (cs_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // A deselect seen in any state ends the frame, even mid-word or with a read in flight.
  always_comb begin
    next_state = state;
    if (cs_s) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:      next_state = CMD;
        CMD:       if (word_ready) next_state = data_word_received[ReadBit] ? RD_FETCH : WR_DATA;
        WR_DATA:   next_state = WR_DATA;
        RD_FETCH:  if (fetch_due) next_state = RD_STREAM;
        RD_STREAM: if (word_ready) next_state = RD_FETCH;
        default:   next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    data_word_to_send = tx_q;
    if (state == IDLE || state == CMD) data_word_to_send = status_word;
  end

  // fetch_due marks the cycle reg_rdata answers the previous reg_re; strobes are gated by cs_s.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_addr     <= '0;
      reg_wdata    <= '0;
      reg_we       <= 1'b0;
      reg_re       <= 1'b0;
      tx_q         <= '0;
      fetch_due    <= 1'b0;
      frame_active <= 1'b0;
    end else begin
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      fetch_due <= reg_re;
      if (reg_we) reg_addr <= reg_addr + AddrBits'(1);
      if (cs_s) begin
        frame_active <= 1'b0;
      end else begin
        case (state)
          CMD: begin
            if (word_ready) begin
              reg_addr     <= data_word_received[AddrBits-1:0];
              frame_active <= 1'b1;
              if (data_word_received[ReadBit]) begin
                tx_q   <= Turnaround;
                reg_re <= 1'b1;
              end else begin
                tx_q <= '0;
              end
            end
          end
          WR_DATA: begin
            if (word_ready) begin
              reg_we    <= 1'b1;
              reg_wdata <= data_word_received;
            end
          end
          RD_FETCH: begin
            if (fetch_due) begin
              tx_q     <= reg_rdata;
              reg_addr <= reg_addr + AddrBits'(1);
            end
          end
          RD_STREAM: begin
            if (word_ready) reg_re <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_controller.sv
// Self-checking bench: emulates spi_secondary framing and a register file, and
// compares MISO slots and register writes against a frame-level reference model.
`timescale 1ns/1ps
module tb_spi_reg_controller;
  import spi_reg_pkg::*;

  localparam int AddrBits = 7;
  localparam int Depth = 128;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs = 1'b1;
  logic       word_ready = 1'b0;
  logic [7:0] data_word_received = 8'h00;
  logic [7:0] status_word = 8'h5A;
  logic [7:0] reg_rdata = 8'h00;
  logic [7:0] data_word_to_send;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic       frame_active;

  int compared = 0;
  int mismatched = 0;

  logic [7:0]  mem [Depth] = '{default: 8'h00};
  logic [7:0]  exp_mem [Depth] = '{default: 8'h00};
  logic [14:0] wr_log[$];
  logic [7:0]  miso[$];
  logic [7:0]  frame_words[$];
  int          rd_count = 0;
  int          overlap_count = 0;

  always #5 clk = ~clk;

  spi_reg_controller dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .cs                (cs),
    .word_ready        (word_ready),
    .data_word_received(data_word_received),
    .data_word_to_send (data_word_to_send),
    .reg_addr          (reg_addr),
    .reg_wdata         (reg_wdata),
    .reg_we            (reg_we),
    .reg_re            (reg_re),
    .reg_rdata         (reg_rdata),
    .status_word       (status_word),
    .frame_active      (frame_active)
  );

  // Register file seen by the controller: read data valid one clock after reg_re.
  always @(posedge clk) begin
    if (reg_we) begin
      mem[reg_addr] <= reg_wdata;
      wr_log.push_back({reg_addr, reg_wdata});
    end
    if (reg_re) begin
      reg_rdata <= mem[reg_addr];
      rd_count++;
    end
    if (reg_we && reg_re) overlap_count++;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic run_frame(input int gap);
    miso.delete();
    cs = 1'b0;
    repeat (4) @(negedge clk);
    miso.push_back(data_word_to_send);
    foreach (frame_words[i]) begin
      repeat (gap - 1) @(negedge clk);
      word_ready = 1'b1;
      data_word_received = frame_words[i];
      @(negedge clk);
      word_ready = 1'b0;
      miso.push_back(data_word_to_send);
    end
  endtask

  task automatic end_frame();
    repeat (3) @(negedge clk);
    cs = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic run_and_check_frame(input string tag, input int gap);
    logic        is_rd;
    logic [6:0]  a;
    logic [6:0]  ak;
    int          n;
    int          rd0;
    logic [7:0]  exp_miso[$];
    logic [14:0] exp_wr[$];
    n = frame_words.size();
    is_rd = frame_words[0][CmdReadBit];
    a = frame_words[0][AddrBits-1:0];
    exp_miso.push_back(status_word);
    for (int k = 1; k <= n; k++) begin
      ak = a + 7'(k - 2);
      if (!is_rd)      exp_miso.push_back(8'h00);
      else if (k == 1) exp_miso.push_back(8'hA5);
      else             exp_miso.push_back(exp_mem[ak]);
    end
    if (!is_rd) begin
      for (int j = 1; j < n; j++) begin
        ak = a + 7'(j - 1);
        exp_wr.push_back({ak, frame_words[j]});
      end
    end
    wr_log.delete();
    rd0 = rd_count;
    run_frame(gap);
    compared++;
    if (frame_active !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL %s frame_active_in_frame got %b want 1", tag, frame_active);
    end
    end_frame();
    compared++;
    if (frame_active !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL %s frame_active_after got %b want 0", tag, frame_active);
    end
    compared++;
    if (data_word_to_send !== status_word) begin
      mismatched++;
      $display("[TB] FAIL %s idle_tx got %h want %h", tag, data_word_to_send, status_word);
    end
    foreach (exp_miso[i]) begin
      compared++;
      if (miso[i] !== exp_miso[i]) begin
        mismatched++;
        $display("[TB] FAIL %s miso_slot%0d got %h want %h", tag, i, miso[i], exp_miso[i]);
      end
    end
    compared++;
    if (wr_log.size() != exp_wr.size()) begin
      mismatched++;
      $display("[TB] FAIL %s write_count got %0d want %0d", tag, wr_log.size(), exp_wr.size());
    end else begin
      foreach (exp_wr[i]) begin
        compared++;
        if (wr_log[i] !== exp_wr[i]) begin
          mismatched++;
          $display("[TB] FAIL %s write%0d addr/data got %h/%h want %h/%h", tag, i,
                   wr_log[i][14:8], wr_log[i][7:0], exp_wr[i][14:8], exp_wr[i][7:0]);
        end
      end
    end
    if (is_rd) begin
      compared++;
      if (rd_count - rd0 != n) begin
        mismatched++;
        $display("[TB] FAIL %s read_count got %0d want %0d", tag, rd_count - rd0, n);
      end
    end
    compared++;
    if (overlap_count !== 0) begin
      mismatched++;
      $display("[TB] FAIL %s we_re_overlap got %0d want 0", tag, overlap_count);
    end
    foreach (exp_wr[i]) exp_mem[exp_wr[i][14:8]] = exp_wr[i][7:0];
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if ({reg_addr, reg_wdata, reg_we, reg_re, frame_active} !== 18'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_regs got addr=%h wdata=%h we=%b re=%b fa=%b want all 0",
               reg_addr, reg_wdata, reg_we, reg_re, frame_active);
    end
    compared++;
    if (data_word_to_send !== status_word) begin
      mismatched++;
      $display("[TB] FAIL reset_tx got %h want %h", data_word_to_send, status_word);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    compared++;
    if (data_word_to_send !== status_word || frame_active !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL post_reset_idle got tx=%h fa=%b want tx=%h fa=0",
               data_word_to_send, frame_active, status_word);
    end
  endtask

  task automatic test_write_basic();
    status_word = 8'h5A;
    frame_words = {8'h05, 8'h11, 8'h22, 8'h33};
    run_and_check_frame("write_basic", 5);
  endtask

  task automatic test_read_basic();
    status_word = 8'h5A;
    frame_words = {8'h05, 8'hC3, 8'h3C};
    run_and_check_frame("read_preload", 4);
    frame_words = {8'h85, 8'h00, 8'hFF, 8'h00};
    run_and_check_frame("read_basic", 5);
  endtask

  task automatic test_wrap();
    frame_words = {8'h7F, 8'hE1, 8'h1E};
    run_and_check_frame("wrap_write", 4);
    frame_words = {8'hFF, 8'h00, 8'h00};
    run_and_check_frame("wrap_read", 3);
  endtask

  task automatic test_reset_mid_frame();
    frame_words = {8'h20};
    wr_log.delete();
    run_frame(4);
    repeat (2) @(negedge clk);
    word_ready = 1'b1;
    data_word_received = 8'h44;
    rst_n = 1'b0;
    #1;
    compared++;
    if ({reg_addr, reg_wdata, reg_we, reg_re, frame_active} !== 18'h0 ||
        data_word_to_send !== status_word) begin
      mismatched++;
      $display("[TB] FAIL reset_mid_frame got addr=%h wdata=%h we=%b re=%b fa=%b tx=%h want zeros tx=%h",
               reg_addr, reg_wdata, reg_we, reg_re, frame_active, data_word_to_send, status_word);
    end
    @(negedge clk);
    word_ready = 1'b0;
    cs = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    compared++;
    if (wr_log.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL reset_mid_frame_writes got %0d want 0", wr_log.size());
    end
  endtask

  task automatic test_abort();
    frame_words = {8'h05, 8'h99};
    wr_log.delete();
    run_frame(5);
    repeat (2) @(negedge clk);
    cs = 1'b1;
    repeat (5) @(negedge clk);
    compared++;
    if (wr_log.size() != 1 || wr_log[0] !== {7'h05, 8'h99}) begin
      mismatched++;
      $display("[TB] FAIL abort_writes got count=%0d want count=1 entry=05/99", wr_log.size());
    end
    compared++;
    if (frame_active !== 1'b0 || data_word_to_send !== status_word) begin
      mismatched++;
      $display("[TB] FAIL abort_idle got fa=%b tx=%h want fa=0 tx=%h",
               frame_active, data_word_to_send, status_word);
    end
    exp_mem[5] = 8'h99;
    frame_words = {8'h10, 8'hAA};
    run_and_check_frame("after_abort", 4);
  endtask

  task automatic test_simultaneous(input logic is_rd);
    int rd0;
    frame_words = {is_rd ? 8'hB0 : 8'h30, 8'h01};
    wr_log.delete();
    run_frame(4);
    repeat (2) @(negedge clk);
    if (!is_rd) exp_mem[7'h30] = 8'h01;
    wr_log.delete();
    rd0 = rd_count;
    cs = 1'b1;
    @(negedge clk);
    @(negedge clk);
    word_ready = 1'b1;
    data_word_received = 8'hEE;
    @(negedge clk);
    word_ready = 1'b0;
    compared++;
    if (data_word_to_send !== status_word || frame_active !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL simultaneous_%0d idle got tx=%h fa=%b want tx=%h fa=0",
               is_rd, data_word_to_send, frame_active, status_word);
    end
    repeat (4) @(negedge clk);
    compared++;
    if (wr_log.size() != 0 || rd_count != rd0) begin
      mismatched++;
      $display("[TB] FAIL simultaneous_%0d strobes got writes=%0d reads=%0d want 0/0",
               is_rd, wr_log.size(), rd_count - rd0);
    end
  endtask

  task automatic test_back_to_back();
    int         n;
    logic       rd;
    logic [6:0] a;
    for (int f = 0; f < 40; f++) begin
      n = $urandom_range(1, 6);
      rd = 1'($urandom_range(0, 1));
      a = 7'($urandom);
      status_word = 8'($urandom);
      frame_words.delete();
      frame_words.push_back({rd, a});
      for (int j = 1; j < n; j++) frame_words.push_back(8'($urandom));
      run_and_check_frame($sformatf("random%0d", f), $urandom_range(3, 7));
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_basic();
    test_wrap();
    test_reset_mid_frame();
    test_abort();
    test_simultaneous(1'b0);
    test_simultaneous(1'b1);
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
